// File: rtl/ysyx_041514_pipe_ctrl_pkg.sv
// Shared control-bus indices, FSM states and flush masks for the pipeline controller.
// Pure constants; no logic and no latency.
package ysyx_041514_pipe_ctrl_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned CTRL_W = 6;

  localparam int unsigned CB_PC     = 0;
  localparam int unsigned CB_IF_ID  = 1;
  localparam int unsigned CB_ID_EX  = 2;
  localparam int unsigned CB_EX_MEM = 3;
  localparam int unsigned CB_MEM_WB = 4;
  localparam int unsigned CB_RSVD   = 5;

  localparam logic [CTRL_W-1:0] FL_EVENT = 6'b001110;
  localparam logic [CTRL_W-1:0] FL_REDIR = 6'b000110;
  localparam logic [CTRL_W-1:0] FL_FENCE = 6'b000110;

  localparam logic [XLEN-1:0] INSN_BYTES = 64'd4;

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_REDIR_PEND  = 2'd1,
    ST_FENCE_FLUSH = 2'd2
  } pc_state_e;

endpackage

// File: rtl/ysyx_041514_stall_decode.sv
// Combinational stall-priority decode: the most downstream requester alone sets the stall
// prefix and the bubble bit just below it. Zero latency; no backpressure of its own.
module ysyx_041514_stall_decode
  import ysyx_041514_pipe_ctrl_pkg::*;
(
  input  logic              i_if_stall,
  input  logic              i_loaduse,
  input  logic              i_ex_busy,
  input  logic              i_mem_stall,
  output logic [CTRL_W-1:0] o_stall,
  output logic [CTRL_W-1:0] o_flush
);

  always_comb begin
    o_stall = '0;
    o_flush = '0;
    if (i_mem_stall) begin
      o_stall[CB_EX_MEM:CB_PC] = '1;
      o_flush[CB_MEM_WB]       = 1'b1;
    end else if (i_ex_busy) begin
      o_stall[CB_ID_EX:CB_PC] = '1;
      o_flush[CB_EX_MEM]      = 1'b1;
    end else if (i_loaduse) begin
      o_stall[CB_IF_ID:CB_PC] = '1;
      o_flush[CB_ID_EX]       = 1'b1;
    end else if (i_if_stall) begin
      o_stall[CB_PC]    = 1'b1;
      o_flush[CB_IF_ID] = 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_041514_pipe_ctrl.sv
// Central pipeline controller: combinational stall/flush buses, immediate or deferred PC redirect,
// fence.i icache invalidation sequencing. Redirect is 0-cycle; deferred while IF is stalled.
module ysyx_041514_pipe_ctrl
  import ysyx_041514_pipe_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall_req_i,
  input  logic              id_loaduse_req_i,
  input  logic              ex_busy_req_i,
  input  logic              mem_stall_req_i,
  input  logic              ex_redirect_valid_i,
  input  logic [XLEN-1:0]   ex_redirect_pc_i,
  input  logic              trap_valid_i,
  input  logic [XLEN-1:0]   trap_pc_i,
  input  logic              fence_i_valid_i,
  input  logic [XLEN-1:0]   fence_pc_i,
  input  logic              icache_flush_done_i,
  output logic [CTRL_W-1:0] stall_valid_o,
  output logic [CTRL_W-1:0] flush_valid_o,
  output logic              pc_redirect_valid_o,
  output logic [XLEN-1:0]   pc_redirect_o,
  output logic              icache_flush_req_o,
  output logic [31:0]       stall_cycles_o
);

  pc_state_e       r_state;
  logic [XLEN-1:0] r_pend_pc;
  logic            r_iflush_pend;
  logic [31:0]     r_stall_cnt;

  logic [CTRL_W-1:0] w_dec_stall;
  logic [CTRL_W-1:0] w_dec_flush;
  logic [CTRL_W-1:0] w_stall;
  logic [CTRL_W-1:0] w_flush;
  logic              w_trap_acc;
  logic              w_fence_acc;
  logic              w_redir_acc;
  logic              w_go;
  logic              w_issue;
  logic [XLEN-1:0]   w_target;

  ysyx_041514_stall_decode u_stall_decode (
    .i_if_stall  (if_stall_req_i),
    .i_loaduse   (id_loaduse_req_i),
    .i_ex_busy   (ex_busy_req_i),
    .i_mem_stall (mem_stall_req_i),
    .o_stall     (w_dec_stall),
    .o_flush     (w_dec_flush)
  );

  // fence.i and EX redirects only start from RUN; a trap is taken in any state.
  assign w_trap_acc  = trap_valid_i & ~mem_stall_req_i;
  assign w_fence_acc = (r_state == ST_RUN) & fence_i_valid_i & ~mem_stall_req_i & ~w_trap_acc;
  assign w_redir_acc = (r_state == ST_RUN) & ex_redirect_valid_i & ~mem_stall_req_i
                     & ~ex_busy_req_i & ~w_trap_acc & ~w_fence_acc;

  always_comb begin
    w_stall  = w_dec_stall;
    w_flush  = w_dec_flush;
    w_go     = 1'b0;
    w_target = r_pend_pc;
    case (r_state)
      ST_REDIR_PEND: begin
        w_stall[CB_PC]    = 1'b1;
        w_flush[CB_IF_ID] = 1'b1;
        w_go              = 1'b1;
      end
      ST_FENCE_FLUSH: begin
        w_stall[CB_PC] = 1'b1;
        w_flush        = w_flush | FL_FENCE;
        w_go           = ~r_iflush_pend | icache_flush_done_i;
      end
      default: ;
    endcase
    if (w_trap_acc) begin
      w_flush  = w_flush | FL_EVENT;
      w_go     = 1'b1;
      w_target = trap_pc_i;
    end else if (w_fence_acc) begin
      w_flush = w_flush | FL_EVENT;
    end else if (w_redir_acc) begin
      w_flush  = w_flush | FL_REDIR;
      w_go     = 1'b1;
      w_target = ex_redirect_pc_i;
    end
    w_issue = w_go & ~if_stall_req_i;
    // The PC must load the redirect target, so an issuing redirect releases the PC stall.
    if (w_issue) begin
      w_stall[CB_PC] = 1'b0;
    end
    w_stall          = w_stall & ~w_flush;
    w_stall[CB_RSVD] = 1'b0;
    w_flush[CB_RSVD] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_pend_pc     <= '0;
      r_iflush_pend <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + {31'd0, w_stall[CB_PC]};
      // A newly accepted fence needs its own invalidation, so set wins over a done pulse.
      if (w_fence_acc) begin
        r_iflush_pend <= 1'b1;
      end else if (icache_flush_done_i) begin
        r_iflush_pend <= 1'b0;
      end
      if (w_issue) begin
        r_state <= ST_RUN;
      end else if (w_go && (r_state != ST_FENCE_FLUSH || w_trap_acc)) begin
        r_state   <= ST_REDIR_PEND;
        r_pend_pc <= w_target;
      end else if (w_fence_acc) begin
        r_state   <= ST_FENCE_FLUSH;
        r_pend_pc <= fence_pc_i + INSN_BYTES;
      end
    end
  end

  assign stall_valid_o       = rst ? '0 : w_stall;
  assign flush_valid_o       = rst ? '0 : w_flush;
  assign pc_redirect_valid_o = ~rst & w_issue;
  assign pc_redirect_o       = (~rst & w_issue) ? w_target : '0;
  assign icache_flush_req_o  = ~rst & r_iflush_pend;
  assign stall_cycles_o      = rst ? '0 : r_stall_cnt;

endmodule
